// File: rtl/mips_core.sv
// mips_core: single-cycle MIPS-subset CPU with branch delay slots and CP0
// exception/interrupt handling. Every instruction fetches, executes and
// retires in the same cycle. All architectural state updates on posedge clk.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   interrupt             level interrupt, appears as Cause.IP[12]
//   macroscopic_pc        PC of the retiring instruction
//   i_inst_addr/_rdata    instruction fetch (combinational read)
//   m_data_addr/_rdata    data memory address / aligned word read
//   m_data_wdata/_byteen  store data (lane-replicated) and byte enables
//   m_int_addr/_byteen    interrupt-generator write port
//   m_inst_addr           PC of the memory-stage instruction (= PC)
//   w_grf_we/_addr/_wdata register write committed at the next posedge
//   w_inst_addr           PC of the writeback-stage instruction (= PC)
module mips_core #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] HANDLER  = 32'h0000_4180,
    parameter logic [31:0] INT_ADDR = 32'h0000_7F20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        interrupt,
    output logic [31:0] macroscopic_pc,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] m_data_addr,
    input  logic [31:0] m_data_rdata,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    output logic [31:0] m_int_addr,
    output logic [3:0]  m_int_byteen,
    output logic [31:0] m_inst_addr,
    output logic        w_grf_we,
    output logic [4:0]  w_grf_addr,
    output logic [31:0] w_grf_wdata,
    output logic [31:0] w_inst_addr
);

    localparam logic [31:0] IM_LO  = 32'h0000_3000;
    localparam logic [31:0] IM_HI  = 32'h0000_6FFC;
    localparam logic [31:0] DM_END = 32'h0000_3000;
    localparam logic [31:0] ERET   = 32'h4200_0018;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    // ---------------------------------------------------------------- state
    logic [31:0] pc_q, pc_d, npc_q, npc_d;
    logic [31:0] grf_q [32];
    logic [5:0]  im_q, im_d;          // SR.IM[15:10]
    logic        exl_q, exl_d, ie_q, ie_d;
    logic        cbd_q, cbd_d;        // Cause.BD
    logic [5:0]  ip_q, ip_d;          // Cause.IP[15:10]
    logic [4:0]  code_q, code_d;      // Cause.ExcCode
    logic [31:0] epc_q, epc_d;
    logic        slot_q, slot_d;      // current instruction sits in a delay slot

    // --------------------------------------------------------------- fields
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] a, b, simm, zimm, mem_addr;
    logic [1:0]  msize;

    assign op    = i_inst_rdata[31:26];
    assign rs    = i_inst_rdata[25:21];
    assign rt    = i_inst_rdata[20:16];
    assign rd    = i_inst_rdata[15:11];
    assign funct = i_inst_rdata[5:0];
    assign imm   = i_inst_rdata[15:0];
    assign a     = grf_q[rs];
    assign b     = grf_q[rt];
    assign simm  = {{16{imm[15]}}, imm};
    assign zimm  = {16'd0, imm};
    assign mem_addr = a + simm;
    // lw/sw end in 2'b11, lh/sh in 2'b01, lb/sb in 2'b00
    assign msize = op[1:0];

    logic [32:0] add_w, sub_w, addi_w;
    assign add_w  = {a[31], a} + {b[31], b};
    assign sub_w  = {a[31], a} - {b[31], b};
    assign addi_w = {a[31], a} + {simm[31], simm};

    logic [31:0] br_tgt, j_tgt, link;
    assign br_tgt = pc_q + 32'd4 + {simm[29:0], 2'b00};
    assign j_tgt  = {pc_q[31:28] + 4'd0, i_inst_rdata[25:0], 2'b00};
    assign link   = pc_q + 32'd8;

    // ------------------------------------------------------------------ CP0
    logic [31:0] sr_val, cause_val, cp0_rd;
    assign sr_val    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    assign cause_val = {cbd_q, 15'd0, ip_q, 3'd0, code_q, 2'b00};

    always_comb begin
        case (rd)
            5'd12:   cp0_rd = sr_val;
            5'd13:   cp0_rd = cause_val;
            5'd14:   cp0_rd = epc_q;
            default: cp0_rd = 32'd0;
        endcase
    end

    // ------------------------------------------------------------ load path
    logic        in_dm, in_int, misal, mem_bad;
    logic [31:0] ld_word, ld_val;
    logic [15:0] ld_half;
    logic [7:0]  ld_byte;

    assign in_dm   = mem_addr < DM_END;
    assign in_int  = (mem_addr >= INT_ADDR) && (mem_addr <= INT_ADDR + 32'd3);
    assign misal   = (msize == 2'b11 && mem_addr[1:0] != 2'b00) ||
                     (msize == 2'b01 && mem_addr[0]);
    assign mem_bad = misal || !(in_dm || in_int);
    // the interrupt-generator window reads back as zero
    assign ld_word = in_dm ? m_data_rdata : 32'd0;
    assign ld_half = mem_addr[1] ? ld_word[31:16] : ld_word[15:0];
    assign ld_byte = ld_word[{mem_addr[1:0], 3'b000} +: 8];

    always_comb begin
        case (msize)
            2'b11:   ld_val = ld_word;
            2'b01:   ld_val = {{16{ld_half[15]}}, ld_half};
            default: ld_val = {{24{ld_byte[7]}}, ld_byte};
        endcase
    end

    // ----------------------------------------------------------- store path
    logic [3:0]  st_be;
    logic [31:0] st_data;

    always_comb begin
        case (msize)
            2'b11: begin
                st_be   = 4'b1111;
                st_data = b;
            end
            2'b01: begin
                st_be   = mem_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{b[15:0]}};
            end
            default: begin
                st_be   = 4'b0001 << mem_addr[1:0];
                st_data = {4{b[7:0]}};
            end
        endcase
    end

    // --------------------------------------------------------------- decode
    logic        wr_en, ovf, ri_exc, sys, is_load, is_store;
    logic        is_cti, redirect, is_eret, is_mtc0;
    logic [4:0]  dst;
    logic [31:0] res, target;

    always_comb begin
        wr_en    = 1'b0;
        dst      = rt;
        res      = 32'd0;
        ovf      = 1'b0;
        ri_exc   = 1'b0;
        sys      = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        is_cti   = 1'b0;
        redirect = 1'b0;
        target   = 32'd0;
        is_eret  = 1'b0;
        is_mtc0  = 1'b0;
        case (op)
            6'h00: begin
                dst = rd;
                case (funct)
                    6'h20: begin wr_en = 1'b1; res = add_w[31:0]; ovf = add_w[32] ^ add_w[31]; end
                    6'h21: begin wr_en = 1'b1; res = a + b; end
                    6'h22: begin wr_en = 1'b1; res = sub_w[31:0]; ovf = sub_w[32] ^ sub_w[31]; end
                    6'h23: begin wr_en = 1'b1; res = a - b; end
                    6'h24: begin wr_en = 1'b1; res = a & b; end
                    6'h25: begin wr_en = 1'b1; res = a | b; end
                    6'h2a: begin wr_en = 1'b1; res = {31'd0, $signed(a) < $signed(b)}; end
                    6'h2b: begin wr_en = 1'b1; res = {31'd0, a < b}; end
                    6'h08: begin is_cti = 1'b1; redirect = 1'b1; target = a; end
                    6'h0c: sys = 1'b1;
                    default: ri_exc = 1'b1;
                endcase
            end
            6'h08: begin wr_en = 1'b1; res = addi_w[31:0]; ovf = addi_w[32] ^ addi_w[31]; end
            6'h09: begin wr_en = 1'b1; res = a + simm; end
            6'h0c: begin wr_en = 1'b1; res = a & zimm; end
            6'h0d: begin wr_en = 1'b1; res = a | zimm; end
            6'h0f: begin wr_en = 1'b1; res = {imm, 16'd0}; end
            6'h23, 6'h21, 6'h20: begin is_load = 1'b1; wr_en = 1'b1; res = ld_val; end
            6'h2b, 6'h29, 6'h28: is_store = 1'b1;
            6'h04: begin is_cti = 1'b1; redirect = (a == b); target = br_tgt; end
            6'h05: begin is_cti = 1'b1; redirect = (a != b); target = br_tgt; end
            6'h02: begin is_cti = 1'b1; redirect = 1'b1; target = j_tgt; end
            6'h03: begin
                is_cti = 1'b1; redirect = 1'b1; target = j_tgt;
                wr_en = 1'b1; dst = 5'd31; res = link;
            end
            6'h10: begin
                if (rs == 5'h00) begin
                    wr_en = 1'b1; res = cp0_rd;
                end else if (rs == 5'h04) begin
                    is_mtc0 = 1'b1;
                end else if (i_inst_rdata == ERET) begin
                    is_eret = 1'b1;
                end else begin
                    ri_exc = 1'b1;
                end
            end
            default: ri_exc = 1'b1;
        endcase
    end

    // ----------------------------------------------------------- exceptions
    logic       fetch_bad, int_req, exc;
    logic [4:0] exc_code;

    assign fetch_bad = (pc_q < IM_LO) || (pc_q > IM_HI) || (pc_q[1:0] != 2'b00);
    // the live input is used so the interrupted instruction is the one on the bus now
    assign int_req   = ((ip_d & im_q) != 6'd0) && ie_q && !exl_q;

    always_comb begin
        exc      = 1'b1;
        exc_code = EXC_INT;
        if (int_req)                   exc_code = EXC_INT;
        else if (fetch_bad)            exc_code = EXC_ADEL;
        else if (ri_exc)               exc_code = EXC_RI;
        else if (sys)                  exc_code = EXC_SYS;
        else if (ovf)                  exc_code = EXC_OV;
        else if (is_load && mem_bad)   exc_code = EXC_ADEL;
        else if (is_store && mem_bad)  exc_code = EXC_ADES;
        else                           exc = 1'b0;
    end

    // -------------------------------------------------------------- outputs
    assign macroscopic_pc = pc_q;
    assign i_inst_addr    = pc_q;
    assign m_inst_addr    = pc_q;
    assign w_inst_addr    = pc_q;
    assign m_data_addr    = mem_addr;
    assign m_int_addr     = mem_addr;
    assign m_data_wdata   = st_data;
    assign m_data_byteen  = (!reset && is_store && !exc && in_dm)  ? st_be : 4'd0;
    assign m_int_byteen   = (!reset && is_store && !exc && in_int) ? st_be : 4'd0;
    assign w_grf_we       = !reset && wr_en && !exc && (dst != 5'd0);
    assign w_grf_addr     = dst;
    assign w_grf_wdata    = res;

    // ----------------------------------------------------------- next state
    always_comb begin
        pc_d   = npc_q;
        npc_d  = redirect ? target : npc_q + 32'd4;
        slot_d = is_cti;
        im_d   = im_q;
        exl_d  = exl_q;
        ie_d   = ie_q;
        cbd_d  = cbd_q;
        code_d = code_q;
        epc_d  = epc_q;
        ip_d   = {3'b000, interrupt, 2'b00};
        if (exc) begin
            epc_d  = slot_q ? pc_q - 32'd4 : pc_q;
            cbd_d  = slot_q;
            code_d = exc_code;
            exl_d  = 1'b1;
            pc_d   = HANDLER;
            npc_d  = HANDLER + 32'd4;
            slot_d = 1'b0;
        end else if (is_eret) begin
            // eret has no delay slot: resume directly at EPC
            exl_d  = 1'b0;
            pc_d   = epc_q;
            npc_d  = epc_q + 32'd4;
            slot_d = 1'b0;
        end else if (is_mtc0) begin
            if (rd == 5'd12) begin
                im_d  = b[15:10];
                exl_d = b[1];
                ie_d  = b[0];
            end else if (rd == 5'd14) begin
                epc_d = b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= PC_RESET;
            npc_q  <= PC_RESET + 32'd4;
            slot_q <= 1'b0;
            im_q   <= 6'd0;
            exl_q  <= 1'b0;
            ie_q   <= 1'b0;
            cbd_q  <= 1'b0;
            ip_q   <= 6'd0;
            code_q <= 5'd0;
            epc_q  <= 32'd0;
        end else begin
            pc_q   <= pc_d;
            npc_q  <= npc_d;
            slot_q <= slot_d;
            im_q   <= im_d;
            exl_q  <= exl_d;
            ie_q   <= ie_d;
            cbd_q  <= cbd_d;
            ip_q   <= ip_d;
            code_q <= code_d;
            epc_q  <= epc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) grf_q[i] <= 32'd0;
        end else if (w_grf_we) begin
            grf_q[dst] <= res;
        end
    end

endmodule

// File: tb/tb_mips_core.sv
module tb_mips_core;

    logic        clk;
    logic        reset;
    logic        interrupt;
    logic [31:0] macroscopic_pc, i_inst_addr, i_inst_rdata;
    logic [31:0] m_data_addr, m_data_rdata, m_data_wdata;
    logic [3:0]  m_data_byteen, m_int_byteen;
    logic [31:0] m_int_addr, m_inst_addr, w_grf_wdata, w_inst_addr;
    logic        w_grf_we;
    logic [4:0]  w_grf_addr;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] NOP  = 32'h3400_0000;   // ori $0,$0,0
    localparam logic [31:0] ERET = 32'h4200_0018;
    localparam logic [31:0] SYSC = 32'h0000_000c;

    logic [31:0] imem [0:4095];
    logic [31:0] dmem [0:4095];
    logic [31:0] ioff;

    mips_core dut (
        .clk(clk), .reset(reset), .interrupt(interrupt),
        .macroscopic_pc(macroscopic_pc),
        .i_inst_addr(i_inst_addr), .i_inst_rdata(i_inst_rdata),
        .m_data_addr(m_data_addr), .m_data_rdata(m_data_rdata),
        .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
        .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen),
        .m_inst_addr(m_inst_addr),
        .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr), .w_grf_wdata(w_grf_wdata),
        .w_inst_addr(w_inst_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ioff = i_inst_addr - 32'h3000;
    assign i_inst_rdata = (i_inst_addr >= 32'h3000 && i_inst_addr < 32'h7000) ? imem[ioff[13:2]] : 32'h0;
    assign m_data_rdata = (m_data_addr < 32'h3000) ? dmem[m_data_addr[13:2]] : 32'h0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4096; i++) dmem[i] <= 32'h0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (m_data_byteen[i]) dmem[m_data_addr[13:2]][i*8 +: 8] <= m_data_wdata[i*8 +: 8];
        end
    end

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction
    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] tgt);
        return {op, tgt[27:2]};
    endfunction
    function automatic logic [31:0] mfc0(input logic [4:0] rt, input logic [4:0] rd);
        return {6'h10, 5'h00, rt, rd, 11'd0};
    endfunction
    function automatic logic [31:0] mtc0(input logic [4:0] rt, input logic [4:0] rd);
        return {6'h10, 5'h04, rt, rd, 11'd0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 4096; i++) imem[i] = NOP;
    endtask

    task automatic put(input logic [31:0] addr, input logic [31:0] w);
        logic [31:0] o;
        o = addr - 32'h3000;
        imem[o[13:2]] = w;
    endtask

    // leaves the core showing the instruction at 0x3000
    task automatic do_reset();
        reset = 1'b1;
        interrupt = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    // fault has just been observed; walk the return-to-EPC+4 handler
    task automatic exc_seq(input string tag, input logic [31:0] cause, input logic [31:0] epc);
        step();
        check({tag, " entry pc"}, macroscopic_pc, 32'h4180);
        check({tag, " cause"}, w_grf_wdata, cause);
        step();
        check({tag, " epc"}, w_grf_wdata, epc);
        repeat (4) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        interrupt = 1'b0;

        // ---------------- program 1: ALU, loads/stores, branches, jumps
        clear_imem();
        put(32'h3000, enc_i(6'h0d, 0, 1, 16'h1234));   // ori  $1,$0,0x1234
        put(32'h3004, enc_i(6'h0f, 0, 2, 16'hABCD));   // lui  $2,0xabcd
        put(32'h3008, enc_i(6'h2b, 0, 1, 16'h0004));   // sw   $1,4($0)
        put(32'h300C, enc_i(6'h28, 0, 1, 16'h0001));   // sb   $1,1($0)
        put(32'h3010, enc_i(6'h21, 0, 3, 16'h0000));   // lh   $3,0($0)
        put(32'h3014, enc_i(6'h09, 0, 4, 16'hFF80));   // addiu $4,$0,-128
        put(32'h3018, enc_i(6'h28, 0, 4, 16'h0002));   // sb   $4,2($0)
        put(32'h301C, enc_i(6'h20, 0, 5, 16'h0002));   // lb   $5,2($0)
        put(32'h3020, enc_i(6'h21, 0, 6, 16'h0002));   // lh   $6,2($0)
        put(32'h3024, enc_i(6'h04, 1, 1, 16'h0006));   // beq  $1,$1,0x3040
        put(32'h3028, enc_r(1, 1, 7, 6'h20));          // add  $7,$1,$1 (slot)
        put(32'h3040, enc_j(6'h03, 32'h3100));         // jal  0x3100
        put(32'h3044, enc_r(2, 1, 8, 6'h23));          // subu $8,$2,$1 (slot)
        put(32'h3100, enc_i(6'h05, 1, 1, 16'h0005));   // bne  $1,$1 (not taken)
        put(32'h3108, enc_r(4, 1, 9, 6'h2a));          // slt  $9,$4,$1
        put(32'h310C, enc_r(4, 1, 10, 6'h2b));         // sltu $10,$4,$1
        put(32'h3110, enc_r(31, 0, 0, 6'h08));         // jr   $31

        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset pc", macroscopic_pc, 32'h3000);
        check("reset grf_we", {31'd0, w_grf_we}, 32'd0);
        check("reset byteen", {28'd0, m_data_byteen}, 32'd0);
        reset = 1'b0;
        #1;

        check("ori pc", macroscopic_pc, 32'h3000);
        check("fetch addr", i_inst_addr, 32'h3000);
        check("m_inst_addr", m_inst_addr, 32'h3000);
        check("w_inst_addr", w_inst_addr, 32'h3000);
        check("ori we", {31'd0, w_grf_we}, 32'd1);
        check("ori addr", {27'd0, w_grf_addr}, 32'd1);
        check("ori data", w_grf_wdata, 32'h0000_1234);
        step();
        check("lui pc", macroscopic_pc, 32'h3004);
        check("lui data", w_grf_wdata, 32'hABCD_0000);
        step();
        check("sw byteen", {28'd0, m_data_byteen}, 32'hF);
        check("sw addr", m_data_addr, 32'h4);
        check("sw data", m_data_wdata, 32'h0000_1234);
        step();
        check("sw mem", dmem[1], 32'h0000_1234);
        check("sb byteen", {28'd0, m_data_byteen}, 32'h2);
        check("sb data", m_data_wdata, 32'h3434_3434);
        step();
        check("lh pos", w_grf_wdata, 32'h0000_3400);
        step();
        check("addiu neg", w_grf_wdata, 32'hFFFF_FF80);
        step();
        check("sb2 byteen", {28'd0, m_data_byteen}, 32'h4);
        step();
        check("lb sext", w_grf_wdata, 32'hFFFF_FF80);
        step();
        check("lh hi", w_grf_wdata, 32'h0000_0080);
        step();
        check("beq no write", {31'd0, w_grf_we}, 32'd0);
        step();
        check("slot pc", macroscopic_pc, 32'h3028);
        check("slot addr", {27'd0, w_grf_addr}, 32'd7);
        check("slot data", w_grf_wdata, 32'h0000_2468);
        step();
        check("br target", macroscopic_pc, 32'h3040);
        check("jal addr", {27'd0, w_grf_addr}, 32'd31);
        check("jal link", w_grf_wdata, 32'h0000_3048);
        step();
        check("jal slot", w_grf_wdata, 32'hABCC_EDCC);
        step();
        check("jal target", macroscopic_pc, 32'h3100);
        step();
        step();
        check("bne fallthru", macroscopic_pc, 32'h3108);
        check("slt", w_grf_wdata, 32'h1);
        step();
        check("sltu", w_grf_wdata, 32'h0);
        step();
        step();
        step();
        check("jr return", macroscopic_pc, 32'h3048);

        // ---------------- program 2: arithmetic overflow
        clear_imem();
        put(32'h3000, enc_i(6'h0f, 0, 1, 16'h7FFF));   // lui  $1,0x7fff
        put(32'h3004, enc_i(6'h08, 1, 1, 16'h7FFF));   // addi $1,$1,0x7fff
        put(32'h3008, enc_i(6'h08, 1, 1, 16'h7FFF));
        put(32'h300C, enc_i(6'h08, 1, 1, 16'h7FFF));   // overflows
        put(32'h4180, mfc0(26, 13));
        put(32'h4184, mfc0(27, 14));
        put(32'h4188, mfc0(28, 12));
        do_reset();
        step();
        check("addi 1", w_grf_wdata, 32'h7FFF_7FFF);
        step();
        check("addi 2", w_grf_wdata, 32'h7FFF_FFFE);
        step();
        check("ov no write", {31'd0, w_grf_we}, 32'd0);
        step();
        check("ov entry pc", macroscopic_pc, 32'h4180);
        check("ov cause", w_grf_wdata, 32'h0000_0030);
        step();
        check("ov epc", w_grf_wdata, 32'h0000_300C);
        step();
        check("ov sr exl", w_grf_wdata, 32'h0000_0002);

        // ---------------- program 3: external interrupt and eret
        clear_imem();
        put(32'h3000, enc_i(6'h0d, 0, 1, 16'h1401));   // ori  $1,$0,0x1401
        put(32'h3004, mtc0(1, 12));                     // SR = 0x1401
        put(32'h3008, enc_i(6'h0d, 0, 2, 16'h0001));
        put(32'h300C, enc_i(6'h0d, 0, 3, 16'h0002));
        put(32'h4180, mfc0(26, 13));
        put(32'h4184, mfc0(27, 14));
        put(32'h4188, ERET);
        do_reset();
        step();
        step();
        interrupt = 1'b1;
        #1;
        check("int pc", macroscopic_pc, 32'h3008);
        check("int no write", {31'd0, w_grf_we}, 32'd0);
        step();
        interrupt = 1'b0;
        #1;
        check("int entry pc", macroscopic_pc, 32'h4180);
        check("int cause", w_grf_wdata, 32'h0000_1000);
        step();
        check("int epc", w_grf_wdata, 32'h0000_3008);
        step();
        step();
        check("eret pc", macroscopic_pc, 32'h3008);
        check("eret replay", w_grf_wdata, 32'h1);
        step();
        check("after eret", macroscopic_pc, 32'h300C);

        // ---------------- program 4: address errors, syscall, RI, int port
        clear_imem();
        put(32'h3000, enc_i(6'h23, 0, 1, 16'h0002));   // lw  $1,2($0)   AdEL
        put(32'h3004, enc_i(6'h0d, 0, 2, 16'h5000));   // ori $2,$0,0x5000
        put(32'h3008, enc_i(6'h2b, 2, 2, 16'h0000));   // sw  $2,0($2)   AdES
        put(32'h300C, SYSC);
        put(32'h3010, 32'hFC00_0000);                   // reserved opcode
        put(32'h3014, enc_i(6'h0d, 0, 3, 16'h7F20));   // ori $3,$0,0x7f20
        put(32'h3018, enc_i(6'h28, 3, 3, 16'h0001));   // sb  $3,1($3)
        put(32'h301C, enc_j(6'h02, 32'h2000));          // j   0x2000
        put(32'h4180, mfc0(26, 13));
        put(32'h4184, mfc0(27, 14));
        put(32'h4188, enc_i(6'h09, 27, 27, 16'h0004));
        put(32'h418C, mtc0(27, 14));
        put(32'h4190, ERET);
        do_reset();
        check("adel no write", {31'd0, w_grf_we}, 32'd0);
        exc_seq("adel", 32'h0000_0010, 32'h3000);
        check("adel resume", macroscopic_pc, 32'h3004);
        step();
        check("ades byteen", {28'd0, m_data_byteen}, 32'd0);
        exc_seq("ades", 32'h0000_0014, 32'h3008);
        exc_seq("syscall", 32'h0000_0020, 32'h300C);
        exc_seq("ri", 32'h0000_0028, 32'h3010);
        step();
        check("int byteen", {28'd0, m_int_byteen}, 32'h2);
        check("int addr", m_int_addr, 32'h0000_7F21);
        check("int dm byteen", {28'd0, m_data_byteen}, 32'd0);
        step();
        step();
        step();
        check("bad fetch pc", macroscopic_pc, 32'h2000);
        check("bad fetch we", {31'd0, w_grf_we}, 32'd0);
        exc_seq("fetch", 32'h0000_0010, 32'h2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
